// File: rtl/mc_mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, functs and datapath selects.
package mc_mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct to ALU control decode; purely combinational, no backpressure.
// Unknown functs fall back to add and raise illegal_o.
module mc_aludec
  import mc_mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    illegal_o    = 1'b0;
    case (funct_i)
      FN_ADD:  alucontrol_o = ALU_ADD;
      FN_SUB:  alucontrol_o = ALU_SUB;
      FN_AND:  alucontrol_o = ALU_AND;
      FN_OR:   alucontrol_o = ALU_OR;
      FN_SLT:  alucontrol_o = ALU_SLT;
      default: illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS Moore controller: 3-5 cycles per instruction, memory states stall on mem_ready.
// Write/strobe outputs are masked combinationally while reset is high.
module mc_controller
  import mc_mips_pkg::*;
#(
  parameter bit EXT_OPS  = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic       is_bne_q, is_bne_d;
  logic       ready;
  logic [2:0] rtype_alu;
  logic       rtype_bad;
  logic       memwrite_raw, irwrite_raw, pcwrite_raw, regwrite_raw, illegal_raw;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  mc_aludec u_aludec (
    .funct_i      (funct),
    .alucontrol_o (rtype_alu),
    .illegal_o    (rtype_bad)
  );

  // Branch flavour is captured in DECODE so op may change while in BRANCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    is_bne_d     = is_bne_q;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_RT;
    zeroext      = 1'b0;
    alucontrol   = ALU_AND;
    pcsrc        = PC_ALU;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread     = 1'b1;
        alusrcb     = SRCB_FOUR;
        alucontrol  = ALU_ADD;
        irwrite_raw = ready;
        pcwrite_raw = ready;
        state_d     = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SH;
        alucontrol = ALU_ADD;
        is_bne_d   = (op == OP_BNE);
        case (op)
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_IEXEC;
          OP_BNE: begin
            if (EXT_OPS) state_d = S_BRANCH;
            else illegal_raw = 1'b1;
          end
          OP_ANDI, OP_ORI: begin
            if (EXT_OPS) state_d = S_IEXEC;
            else illegal_raw = 1'b1;
          end
          default:        illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_RT;
        alucontrol  = rtype_bad ? ALU_ADD : rtype_alu;
        illegal_raw = rtype_bad;
        state_d     = rtype_bad ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_RT;
        alucontrol  = ALU_SUB;
        pcsrc       = PC_ALUOUT;
        pcwrite_raw = is_bne_q ? ~zero : zero;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_IWB;
        if (EXT_OPS && op == OP_ANDI) begin
          alucontrol = ALU_AND;
          zeroext    = 1'b1;
        end else if (EXT_OPS && op == OP_ORI) begin
          alucontrol = ALU_OR;
          zeroext    = 1'b1;
        end else begin
          alucontrol = ALU_ADD;
        end
      end
      S_IWB:  regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc       = PC_JUMP;
        pcwrite_raw = 1'b1;
      end
      default: begin
        memread    = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
      end
    endcase
  end

  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign pcwrite  = pcwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign illegal  = illegal_raw  & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction table plus hand sequences for stalls, reset and EXT_OPS=0.
module tb_mc_controller;
  import mc_mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memread, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite;
  logic       alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       n_iord, n_memread, n_memwrite, n_irwrite, n_pcwrite, n_regdst, n_memtoreg;
  logic       n_regwrite, n_alusrca, n_zeroext, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [2:0] n_alucontrol;
  logic [3:0] n_state;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .illegal(illegal), .state(state)
  );

  mc_controller #(.EXT_OPS(1'b0)) dut_noext (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(n_iord), .memread(n_memread), .memwrite(n_memwrite), .irwrite(n_irwrite),
    .pcwrite(n_pcwrite), .regdst(n_regdst), .memtoreg(n_memtoreg), .regwrite(n_regwrite),
    .alusrca(n_alusrca), .alusrcb(n_alusrcb), .zeroext(n_zeroext), .alucontrol(n_alucontrol),
    .pcsrc(n_pcsrc), .illegal(n_illegal), .state(n_state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       rw, mw, pw, il;
  } exp_t;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    logic       z;
    int         ncyc;
    logic [23:0] sts;
    logic [5:0] rw, mw, pw, il;
    logic       chk_alu;
    logic [2:0] alu;
    logic       zx;
  } row_t;

  exp_t exp_q[$];
  row_t rows[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, want);
  endtask

  task automatic push(input logic [3:0] st, input logic rw, mw, pw, il);
    exp_t e;
    e = {st, rw, mw, pw, il};
    exp_q.push_back(e);
  endtask

  // Pops one expected record and compares it at the falling edge.
  task automatic cyc_chk(input string nm);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({nm, " scoreboard empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " state"}, state, e.st);
      chk({nm, " regwrite"}, regwrite, e.rw);
      chk({nm, " memwrite"}, memwrite, e.mw);
      chk({nm, " pcwrite"}, pcwrite, e.pw);
      chk({nm, " illegal"}, illegal, e.il);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic [5:0] o, f, input logic z, input int n,
                     input logic [23:0] s, input logic [5:0] rw, mw, pw, il,
                     input logic ca, input logic [2:0] alu, input logic zx);
    row_t r;
    r.nm = nm; r.op = o; r.fn = f; r.z = z; r.ncyc = n; r.sts = s;
    r.rw = rw; r.mw = mw; r.pw = pw; r.il = il; r.chk_alu = ca; r.alu = alu; r.zx = zx;
    rows.push_back(r);
  endtask

  task automatic run_row(input row_t r);
    op = r.op; funct = r.fn; zero = r.z;
    for (int c = 0; c < r.ncyc; c++)
      push(r.sts[4*c +: 4], r.rw[c], r.mw[c], r.pw[c], r.il[c]);
    for (int c = 0; c < r.ncyc; c++) begin
      cyc_chk($sformatf("%s c%0d", r.nm, c));
      if (c == 2 && r.chk_alu) begin
        chk({r.nm, " alucontrol"}, alucontrol, r.alu);
        chk({r.nm, " zeroext"}, zeroext, r.zx);
      end
      adv();
    end
  endtask

  task automatic noext_illegal(input string nm, input logic [5:0] o);
    reset = 1'b1; mem_ready = 1'b1;
    adv();
    reset = 1'b0; op = o;
    @(negedge clk);
    chk({nm, " noext fetch state"}, n_state, 0);
    adv();
    @(negedge clk);
    chk({nm, " noext decode state"}, n_state, 1);
    chk({nm, " noext illegal"}, n_illegal, 1);
    adv();
    @(negedge clk);
    chk({nm, " noext back to fetch"}, n_state, 0);
    chk({nm, " noext illegal cleared"}, n_illegal, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    add("lw",   OP_LW,   6'b0,   1'b0, 5, 24'h043210, 6'b010000, 6'b0,      6'b000001, 6'b0,      1'b1, ALU_ADD, 1'b0);
    add("sw",   OP_SW,   6'b0,   1'b0, 4, 24'h005210, 6'b0,      6'b001000, 6'b000001, 6'b0,      1'b1, ALU_ADD, 1'b0);
    add("add",  OP_RTYPE, FN_ADD, 1'b0, 4, 24'h007610, 6'b001000, 6'b0,     6'b000001, 6'b0,      1'b1, 3'b010,  1'b0);
    add("sub",  OP_RTYPE, FN_SUB, 1'b0, 4, 24'h007610, 6'b001000, 6'b0,     6'b000001, 6'b0,      1'b1, 3'b110,  1'b0);
    add("and",  OP_RTYPE, FN_AND, 1'b0, 4, 24'h007610, 6'b001000, 6'b0,     6'b000001, 6'b0,      1'b1, 3'b000,  1'b0);
    add("or",   OP_RTYPE, FN_OR,  1'b0, 4, 24'h007610, 6'b001000, 6'b0,     6'b000001, 6'b0,      1'b1, 3'b001,  1'b0);
    add("slt",  OP_RTYPE, FN_SLT, 1'b0, 4, 24'h007610, 6'b001000, 6'b0,     6'b000001, 6'b0,      1'b1, 3'b111,  1'b0);
    add("rbad", OP_RTYPE, 6'b0,  1'b0, 3, 24'h000610, 6'b0,      6'b0,      6'b000001, 6'b000100, 1'b1, 3'b010,  1'b0);
    add("beq1", OP_BEQ,  6'b0,   1'b1, 3, 24'h000810, 6'b0,      6'b0,      6'b000101, 6'b0,      1'b1, 3'b110,  1'b0);
    add("beq0", OP_BEQ,  6'b0,   1'b0, 3, 24'h000810, 6'b0,      6'b0,      6'b000001, 6'b0,      1'b1, 3'b110,  1'b0);
    add("bne1", OP_BNE,  6'b0,   1'b1, 3, 24'h000810, 6'b0,      6'b0,      6'b000001, 6'b0,      1'b1, 3'b110,  1'b0);
    add("bne0", OP_BNE,  6'b0,   1'b0, 3, 24'h000810, 6'b0,      6'b0,      6'b000101, 6'b0,      1'b1, 3'b110,  1'b0);
    add("j",    OP_J,    6'b0,   1'b0, 3, 24'h000B10, 6'b0,      6'b0,      6'b000101, 6'b0,      1'b1, 3'b000,  1'b0);
    add("addi", OP_ADDI, 6'b0,   1'b0, 4, 24'h00A910, 6'b001000, 6'b0,      6'b000001, 6'b0,      1'b1, 3'b010,  1'b0);
    add("andi", OP_ANDI, 6'b0,   1'b0, 4, 24'h00A910, 6'b001000, 6'b0,      6'b000001, 6'b0,      1'b1, 3'b000,  1'b1);
    add("ori",  OP_ORI,  6'b0,   1'b0, 4, 24'h00A910, 6'b001000, 6'b0,      6'b000001, 6'b0,      1'b1, 3'b001,  1'b1);
    add("illop", 6'b111111, 6'b0, 1'b0, 2, 24'h000010, 6'b0,     6'b0,      6'b000001, 6'b000010, 1'b0, 3'b000,  1'b0);

    // Strobes masked while reset is held, even though FETCH with mem_ready=1 would assert them.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset state", state, 0);
    chk("reset pcwrite", pcwrite, 0);
    chk("reset irwrite", irwrite, 0);
    chk("reset memwrite", memwrite, 0);
    adv();
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("post-reset state", state, 0);
    chk("post-reset memread", memread, 1);
    chk("post-reset alusrcb", alusrcb, 1);
    chk("post-reset alucontrol", alucontrol, 3'b010);
    chk("post-reset irwrite", irwrite, 0);
    chk("post-reset pcwrite", pcwrite, 0);
    chk("post-reset others", {iord, memwrite, regdst, memtoreg, regwrite, alusrca, zeroext, pcsrc, illegal}, 0);
    adv();
    mem_ready = 1'b1;

    foreach (rows[i]) run_row(rows[i]);

    // lw with two extra MEMRD wait cycles.
    op = OP_LW;
    push(0, 0, 0, 1, 0); cyc_chk("lwwait c0"); adv();
    push(1, 0, 0, 0, 0); cyc_chk("lwwait c1"); adv();
    push(2, 0, 0, 0, 0); cyc_chk("lwwait c2"); adv();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      push(3, 0, 0, 0, 0); cyc_chk($sformatf("lwwait memrd%0d", k));
      chk("lwwait iord", iord, 1);
      chk("lwwait memread", memread, 1);
      adv();
    end
    push(4, 1, 0, 0, 0); cyc_chk("lwwait memwb");
    chk("lwwait memtoreg", memtoreg, 1);
    adv();

    // sw with mem_ready low for three MEMWR cycles: four memwrite cycles in total.
    op = OP_SW;
    push(0, 0, 0, 1, 0); cyc_chk("swwait c0"); adv();
    push(1, 0, 0, 0, 0); cyc_chk("swwait c1"); adv();
    push(2, 0, 0, 0, 0); cyc_chk("swwait c2"); adv();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      push(5, 0, 1, 0, 0); cyc_chk($sformatf("swwait memwr%0d", k));
      adv();
    end
    mem_ready = 1'b0;
    push(0, 0, 0, 0, 0); cyc_chk("fetch stall");
    chk("fetch stall irwrite", irwrite, 0);
    adv();
    push(0, 0, 0, 0, 0); cyc_chk("fetch stall 2");
    adv();
    mem_ready = 1'b1;

    // Reset raised while MEMWR is waiting.
    push(0, 0, 0, 1, 0); cyc_chk("swrst c0"); adv();
    push(1, 0, 0, 0, 0); cyc_chk("swrst c1"); adv();
    push(2, 0, 0, 0, 0); cyc_chk("swrst c2"); adv();
    mem_ready = 1'b0;
    push(5, 0, 1, 0, 0); cyc_chk("swrst wait"); adv();
    reset = 1'b1;
    push(5, 0, 0, 0, 0); cyc_chk("swrst reset in memwr"); adv();
    reset = 1'b0;
    push(0, 0, 0, 0, 0); cyc_chk("swrst after edge");
    chk("swrst memread", memread, 1);
    adv();
    mem_ready = 1'b1;

    // bne decision must not follow op changes made after DECODE.
    op = OP_BNE; zero = 1'b0;
    push(0, 0, 0, 1, 0); cyc_chk("bnehold c0"); adv();
    push(1, 0, 0, 0, 0); cyc_chk("bnehold c1"); adv();
    op = OP_BEQ;
    push(8, 0, 0, 1, 0); cyc_chk("bnehold branch"); adv();

    noext_illegal("bne", OP_BNE);
    noext_illegal("andi", OP_ANDI);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter EXT_OPS, default 1: 1 enables bne/andi/ori decode; 0 treats those opcodes as illegal.
REQ-002 Parameter MEM_WAIT, default 1: 1 makes memory states wait on mem_ready; 0 ignores mem_ready (treated as 1).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- memread  out  1  read request.
- memwrite  out  1  write request.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  PC enable, already qualified by branch/zero.
- regdst  out  1  1 = rd; 0 = rt.
- memtoreg  out  1  1 = data register; 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0 = PC; 1 = rs.
- alusrcb  out  2  00 = rt; 01 = constant 4; 10 = extended imm; 11 = extended imm<<2.
- zeroext  out  1  1 = zero-extend imm; 0 = sign-extend.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pcsrc  out  2  00 = ALU result; 01 = ALUOut; 10 = jump target.
- illegal  out  1  one-cycle pulse for an undecodable op or funct.
- state  out  4  current state, for debug.

Function
REQ-005 Moore FSM; outputs are combinational from state, plus zero and mem_ready where stated; every output not listed for a state is 0.
REQ-006 FETCH (0): memread=1, alusrcb=01, alucontrol=add; irwrite=pcwrite=mem_ready; stay in FETCH until mem_ready, then go to DECODE.
REQ-007 DECODE (1): alusrcb=11, alucontrol=add.
- op 000000 -> EXECUTE; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> IEXEC.
- EXT_OPS=1 also: 000101 -> BRANCH; 001100 or 001101 -> IEXEC.
- Any other op: illegal=1, next state FETCH.
REQ-008 MEMADR (2): alusrca=1, alusrcb=10, alucontrol=add; lw -> MEMRD, sw -> MEMWR.
REQ-009 MEMRD (3): iord=1, memread=1; hold until mem_ready, then go to MEMWB.
REQ-010 MEMWB (4): memtoreg=1, regwrite=1; next state FETCH.
REQ-011 MEMWR (5): iord=1, memwrite=1, held every cycle until mem_ready; next state FETCH.
REQ-012 EXECUTE (6): alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> ALUWB; unknown funct: alucontrol=010, illegal=1, next state FETCH, no register write.
REQ-013 ALUWB (7): regdst=1, regwrite=1; next state FETCH.
REQ-014 BRANCH (8): alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01; pcwrite=zero for beq, ~zero for bne; next state FETCH.
REQ-015 IEXEC (9): alusrca=1, alusrcb=10; addi: add, zeroext=0; andi: and, zeroext=1; ori: or, zeroext=1; next state IWB.
REQ-016 IWB (10): regwrite=1, memtoreg=0, regdst=0; next state FETCH.
REQ-017 JUMP (11): pcsrc=10, pcwrite=1; next state FETCH.
REQ-018 Unused encodings 12-15 behave as FETCH outputs with pcwrite=irwrite=0 and next state FETCH.
REQ-019 Instruction latency with mem_ready=1: lw 5 cycles; sw, R-type, addi/andi/ori 4; beq/bne/j 3; each wait cycle adds 1.
REQ-020 op and funct are sampled only in DECODE/EXECUTE/MEMADR/IEXEC; changes elsewhere have no effect.

Reset
REQ-021 On a rising clk edge with reset=1, state becomes FETCH.
REQ-022 While reset=1, memwrite, regwrite, pcwrite, irwrite and illegal are forced to 0 combinationally, including when reset is asserted mid-MEMWR or mid-wait.
REQ-023 After reset deasserts, the first cycle is FETCH, with all strobes 0 except memread=1 and alusrcb=01.

Structure
REQ-024 Package mc_mips_pkg holds the state enum (4-bit), opcode and funct constants, and the alucontrol/alusrcb/pcsrc encodings.
REQ-025 Sub-module mc_aludec does the funct-to-alucontrol decode and the illegal-funct flag; the FSM is in mc_controller.

Verification
REQ-026 lw, mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-027 sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH.
REQ-028 beq zero=1 -> pcwrite=1 in BRANCH; bne zero=1 -> pcwrite=0; EXT_OPS=0 with bne -> illegal pulse in DECODE, then FETCH.
REQ-029 ori -> IEXEC with alucontrol=001, zeroext=1, then IWB regwrite=1; addi -> zeroext=0, alucontrol=010.
REQ-030 R-type funct 000000 -> illegal=1 in EXECUTE, no ALUWB, regwrite never 1.
REQ-031 reset raised during MEMWR wait -> memwrite=0 that same cycle; state=0 after the edge.
